// File: rtl/defog_pkg.sv
// Shared types and constants for the defog atmospheric-light parameter controller.
// Holds the FSM state encoding, the dark-channel width and the reset default.
package defog_pkg;

    localparam int DARK_W = 8;
    localparam logic [DARK_W-1:0] DARK_INIT_DEFAULT = 8'd220;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        COMMIT   = 2'd2
    } state_t;

endpackage

// File: rtl/defog_al_filter.sv
// Clamp of the frame maximum into [amin, amax]; optional IIR smoothing under
// DEFOG_PARAM_IIR_EN.
module defog_al_filter
    import defog_pkg::*;
(
    input  logic [DARK_W-1:0] acc_max,
    input  logic [DARK_W-1:0] cfg_amin,
    input  logic [DARK_W-1:0] cfg_amax,
`ifdef DEFOG_PARAM_IIR_EN
    input  logic [DARK_W-1:0] prev,
`endif
    output logic [DARK_W-1:0] dark_next
);

    logic [DARK_W-1:0] lo;
    logic [DARK_W-1:0] clamped;

    // Upper clamp applied last so an inverted range resolves to amax.
    always_comb begin
        lo      = (acc_max < cfg_amin) ? cfg_amin : acc_max;
        clamped = (lo > cfg_amax) ? cfg_amax : lo;
    end

`ifdef DEFOG_PARAM_IIR_EN
    always_comb begin
        dark_next = DARK_W'((10'(prev) * 10'd3 + 10'(clamped) + 10'd2) >> 2);
    end
`else
    always_comb begin
        dark_next = clamped;
    end
`endif

endmodule

// File: rtl/defog_param_ctrl.sv
// Per-frame atmospheric-light tracker: max of dark channel, committed at vsync.
// Optional IIR smoothing of the committed value with DEFOG_PARAM_IIR_EN.
module defog_param_ctrl
    import defog_pkg::*;
#(
    parameter logic [DARK_W-1:0] DARK_INIT = DARK_INIT_DEFAULT,
    parameter int                FCNT_W    = 16
) (
    input  logic              pixelclk,
    input  logic              reset_n,
    input  logic              i_vsync,
    input  logic              i_de,
    input  logic [DARK_W-1:0] i_dark,
    input  logic [DARK_W-1:0] cfg_amin,
    input  logic [DARK_W-1:0] cfg_amax,
    input  logic              cfg_bypass,
    output logic [DARK_W-1:0] o_dark_max,
    output logic              o_bypass,
    output logic              o_param_valid,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic              vs_q;
    logic              vs_edge;
    logic [DARK_W-1:0] acc_max;
    logic              seen;
    logic [DARK_W-1:0] dark_next;

    assign vs_edge = i_vsync & ~vs_q;

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_SOF;
            vs_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            vs_q  <= i_vsync;
        end
    end

    // Edges during COMMIT are dropped; frames are at least two cycles long.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_SOF: if (vs_edge) state_nxt = ACCUM;
            ACCUM:    if (vs_edge) state_nxt = COMMIT;
            COMMIT:   state_nxt = ACCUM;
            default:  state_nxt = WAIT_SOF;
        endcase
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            acc_max <= '0;
            seen    <= 1'b0;
        end else begin
            unique case (state)
                WAIT_SOF: begin
                    if (vs_edge) begin
                        acc_max <= '0;
                        seen    <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (i_de) begin
                        if (i_dark > acc_max) acc_max <= i_dark;
                        seen <= 1'b1;
                    end
                end
                COMMIT: begin
                    acc_max <= '0;
                    seen    <= 1'b0;
                end
                default: begin
                    acc_max <= '0;
                    seen    <= 1'b0;
                end
            endcase
        end
    end

    defog_al_filter u_filter (
        .acc_max   (acc_max),
        .cfg_amin  (cfg_amin),
        .cfg_amax  (cfg_amax),
`ifdef DEFOG_PARAM_IIR_EN
        .prev      (o_dark_max),
`endif
        .dark_next (dark_next)
    );

    // Empty frames keep the previous parameters and do not count.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_dark_max    <= DARK_INIT;
            o_bypass      <= 1'b0;
            o_param_valid <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_param_valid <= 1'b0;
            if (state == COMMIT && seen) begin
                o_dark_max    <= dark_next;
                o_bypass      <= cfg_bypass;
                o_param_valid <= 1'b1;
                o_frame_cnt   <= o_frame_cnt + {{(FCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_defog_param_ctrl.sv
// Scoreboard bench for defog_param_ctrl: directed frames, queue of expected
// commits, monitor checks every commit and the hold behaviour between them.
module tb_defog_param_ctrl;

    logic       pixelclk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       i_vsync  = 1'b0;
    logic       i_de     = 1'b0;
    logic [7:0] i_dark   = 8'd0;
    logic [7:0] cfg_amin = 8'd0;
    logic [7:0] cfg_amax = 8'd255;
    logic       cfg_bypass = 1'b0;
    logic [7:0]  o_dark_max;
    logic        o_bypass;
    logic        o_param_valid;
    logic [15:0] o_frame_cnt;

    defog_param_ctrl dut (
        .pixelclk      (pixelclk),
        .reset_n       (reset_n),
        .i_vsync       (i_vsync),
        .i_de          (i_de),
        .i_dark        (i_dark),
        .cfg_amin      (cfg_amin),
        .cfg_amax      (cfg_amax),
        .cfg_bypass    (cfg_bypass),
        .o_dark_max    (o_dark_max),
        .o_bypass      (o_bypass),
        .o_param_valid (o_param_valid),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 pixelclk = ~pixelclk;

    typedef struct {
        int cyc;
        int dark;
        int byp;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge pixelclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reference copy of the frame-stable outputs.
    int m_dark = 220;
    int m_byp  = 0;
    int m_cnt  = 0;

    always @(negedge pixelclk) begin
        if (!reset_n) begin
            m_dark = 220;
            m_byp  = 0;
            m_cnt  = 0;
        end else if (o_param_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("commit_latency", cyc, e.cyc);
                chk("commit_dark", int'(o_dark_max), e.dark);
                chk("commit_bypass", int'(o_bypass), e.byp);
                chk("commit_cnt", int'(o_frame_cnt), e.cnt);
                m_dark = e.dark;
                m_byp  = e.byp;
                m_cnt  = e.cnt;
            end
        end else begin
            chk("hold_dark", int'(o_dark_max), m_dark);
            chk("hold_bypass", int'(o_bypass), m_byp);
            chk("hold_cnt", int'(o_frame_cnt), m_cnt);
        end
    end

    // Stimulus-side expectation state.
    int exp_cnt = 0;
    int prev    = 220;
    int fmax    = 0;
    bit seen    = 1'b0;

    function automatic int filt(input int p, input int a, input int lo, input int hi);
        int c;
        c = (a < lo) ? lo : a;
        c = (c > hi) ? hi : c;
`ifdef DEFOG_PARAM_IIR_EN
        return ((3 * p + c + 2) >> 2) & 255;
`else
        return c + 0 * p;
`endif
    endfunction

    task automatic pixels(input int n, input int top);
        for (int i = 0; i < n; i++) begin
            if (i % 3 == 2) begin
                i_de   = 1'b0;
                i_dark = 8'hff;
            end else begin
                i_de   = 1'b1;
                i_dark = (i == 0) ? 8'(top) : 8'(top - 1 - (i % 4));
                if (int'(i_dark) > fmax) fmax = int'(i_dark);
                seen = 1'b1;
            end
            @(negedge pixelclk);
        end
        i_de   = 1'b0;
        i_dark = 8'hff;
    endtask

    task automatic vs_edge(input bit commit, input bit de, input int dark);
        i_vsync = 1'b1;
        i_de    = de;
        i_dark  = 8'(dark);
        if (de) begin
            if (dark > fmax) fmax = dark;
            seen = 1'b1;
        end
        if (commit && seen) begin
            exp_cnt = (exp_cnt + 1) & 16'hffff;
            prev    = filt(prev, fmax, int'(cfg_amin), int'(cfg_amax));
            q.push_back('{cyc + 2, prev, int'(cfg_bypass), exp_cnt});
        end
        fmax = 0;
        seen = 1'b0;
        @(negedge pixelclk);
        i_de   = 1'b0;
        i_dark = 8'hff;
        @(negedge pixelclk);
        i_vsync = 1'b0;
        @(negedge pixelclk);
    endtask

    initial begin
        repeat (3) @(negedge pixelclk);
        chk("rst_dark", int'(o_dark_max), 220);
        chk("rst_bypass", int'(o_bypass), 0);
        chk("rst_valid", int'(o_param_valid), 0);
        chk("rst_cnt", int'(o_frame_cnt), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge pixelclk);

        vs_edge(1'b0, 1'b0, 0);
        pixels(9, 180);
        vs_edge(1'b1, 1'b0, 0);

        cfg_amax = 8'd230;
        pixels(9, 250);
        vs_edge(1'b1, 1'b0, 0);

        cfg_amax = 8'd255;
        cfg_amin = 8'd100;
        pixels(9, 40);
        vs_edge(1'b1, 1'b0, 0);

        cfg_amin = 8'd200;
        cfg_amax = 8'd150;
        pixels(9, 180);
        vs_edge(1'b1, 1'b0, 0);

        cfg_amin = 8'd0;
        cfg_amax = 8'd255;
        i_de   = 1'b0;
        i_dark = 8'hff;
        repeat (8) @(negedge pixelclk);
        vs_edge(1'b1, 1'b0, 0);

        pixels(6, 90);
        cfg_bypass = 1'b1;
        pixels(6, 60);
        vs_edge(1'b1, 1'b0, 0);

        pixels(9, 120);
        vs_edge(1'b1, 1'b1, 200);

        cfg_bypass = 1'b0;
        pixels(5, 70);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_dark", int'(o_dark_max), 220);
        chk("async_rst_bypass", int'(o_bypass), 0);
        chk("async_rst_valid", int'(o_param_valid), 0);
        chk("async_rst_cnt", int'(o_frame_cnt), 0);
        exp_cnt = 0;
        prev    = 220;
        fmax    = 0;
        seen    = 1'b0;
        i_de    = 1'b0;
        @(negedge pixelclk);
        @(negedge pixelclk);
        reset_n = 1'b1;
        pixels(6, 250);
        fmax = 0;
        seen = 1'b0;
        vs_edge(1'b0, 1'b0, 0);
        pixels(9, 100);
        vs_edge(1'b1, 1'b0, 0);
        pixels(9, 100);
        vs_edge(1'b1, 1'b0, 0);
        repeat (4) @(negedge pixelclk);

`ifdef DEFOG_PARAM_IIR_EN
        chk("iir_final_dark", int'(o_dark_max), 168);
`else
        chk("final_dark", int'(o_dark_max), 100);
`endif
        chk("final_cnt", int'(o_frame_cnt), 2);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
